// File: rtl/wb_rr_arbiter_if.sv
// Wishbone signal bundle for the round-robin arbiter.
// The master modport is the arbiter's view: it serves the requesters and masters the interconnect.
interface wb_rr_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    logic [NUM_MASTERS-1:0]    m_STB;
    logic [NUM_MASTERS-1:0]    m_WE;
    logic [32*NUM_MASTERS-1:0] m_ADDR;
    logic [32*NUM_MASTERS-1:0] m_DAT_I;
    logic [31:0]               m_DAT_O;
    logic [NUM_MASTERS-1:0]    m_ACK;

    logic        bus_STB;
    logic        bus_WE;
    logic [31:0] bus_ADDR;
    logic [31:0] bus_DAT_O;
    logic [31:0] bus_DAT_I;
    logic        bus_ACK;

    modport master (
        input  m_STB, m_WE, m_ADDR, m_DAT_I, bus_DAT_I, bus_ACK,
        output m_DAT_O, m_ACK, bus_STB, bus_WE, bus_ADDR, bus_DAT_O
    );

    modport slave (
        output m_STB, m_WE, m_ADDR, m_DAT_I, bus_DAT_I, bus_ACK,
        input  m_DAT_O, m_ACK, bus_STB, bus_WE, bus_ADDR, bus_DAT_O
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N requesters share one interconnect master slot, locked until ACK.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int GRANT_W     = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               rst,
    wb_rr_arbiter_if.master    wb,
    output logic [GRANT_W-1:0] grant,
    output logic               busy,
    output logic               bus_err
);

    // state | meaning
    // IDLE  | no transfer; bus_STB low; arbitrate among requesters
    // BUSY  | master[grant] owns the bus until ACK, abort or timeout
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [GRANT_W-1:0] last_grant;
    logic [GRANT_W-1:0] pick;
    logic [GRANT_W-1:0] cand;
    logic               pick_valid;
    logic               active;
    logic               cur_stb;
    logic               tmo;

    logic [31:0] addr_arr [NUM_MASTERS];
    logic [31:0] dat_arr  [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign addr_arr[i] = wb.m_ADDR[32*i +: 32];
        assign dat_arr[i]  = wb.m_DAT_I[32*i +: 32];
    end

    // Scan downward so the nearest requester after last_grant is the last one written.
    always_comb begin
        pick       = last_grant;
        pick_valid = 1'b0;
        cand       = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = GRANT_W'((int'(last_grant) + k) % NUM_MASTERS);
            if (wb.m_STB[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    assign active  = (state == BUSY) && !rst;
    assign cur_stb = wb.m_STB[grant];

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Held at zero in IDLE, so it starts from zero on every BUSY entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign tmo = active && !wb.bus_ACK && (tmo_cnt == CNT_W'(TIMEOUT));
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = BUSY;
            BUSY:    if (wb.bus_ACK || !cur_stb || tmo) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GRANT_W'(NUM_MASTERS - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_valid) begin
                grant      <= pick;
                last_grant <= pick;
            end
        end
    end

    assign wb.bus_STB   = active && cur_stb && !tmo;
    assign wb.bus_WE    = wb.m_WE[grant];
    assign wb.bus_ADDR  = addr_arr[grant];
    assign wb.bus_DAT_O = dat_arr[grant];
    assign wb.m_DAT_O   = tmo ? 32'h0 : wb.bus_DAT_I;

    // An ACK landing in a reset cycle never reaches the requester.
    always_comb begin
        wb.m_ACK = '0;
        if (active) wb.m_ACK[grant] = wb.bus_ACK || tmo;
    end

    assign busy    = (state == BUSY);
    assign bus_err = tmo;

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Multi-master Wishbone arbiter placed in front of the single-master WB interconnect; lets CPU data port, instruction fetch, VGA/DMA, etc. share the one master slot.
- Round-robin grant with lock held for the whole transfer (STB asserted until ACK).
- The interconnect, and through it the slaves, see one ordinary master; each requester sees a private WB master port.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- GRANT_W, 2, width of grant index; must satisfy 2**GRANT_W >= NUM_MASTERS.
- TIMEOUT, 255, watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- m_STB  input  NUM_MASTERS  per-master strobe, bit i = master i.
- m_WE  input  NUM_MASTERS  per-master write enable.
- m_ADDR  input  32*NUM_MASTERS  per-master address, master i at [32i+31:32i].
- m_DAT_I  input  32*NUM_MASTERS  per-master write data, same packing.
- m_DAT_O  output  32  read data broadcast to all masters.
- m_ACK  output  NUM_MASTERS  per-master acknowledge.
- bus_STB  output  1  strobe to interconnect.
- bus_WE  output  1  write enable to interconnect.
- bus_ADDR  output  32  address to interconnect.
- bus_DAT_O  output  32  write data to interconnect.
- bus_DAT_I  input  32  read data from interconnect.
- bus_ACK  input  1  acknowledge from interconnect.
- grant  output  GRANT_W  index of the current/last granted master.
- busy  output  1  high while in BUSY.
- bus_err  output  1  one-cycle timeout pulse (0 without macro).

Behaviour:
- Reset: state=IDLE, grant=0, last_grant=NUM_MASTERS-1 (master 0 has first priority), busy=0, bus_STB=0, m_ACK=0, bus_err=0, timeout counter=0. Reset mid-transfer aborts immediately; any ACK arriving in the reset cycle is dropped.
- FSM states: IDLE, BUSY.
- IDLE:
  - bus_STB=0 and m_ACK=0.
  - If any m_STB is set, pick the first requester scanning from last_grant+1 upward, wrapping modulo NUM_MASTERS.
  - Register the pick into grant and last_grant, then go to BUSY. Arbitration latency is 1 cycle.
- BUSY:
  - Combinational routing from master[grant]: bus_STB=m_STB[grant], bus_WE=m_WE[grant], bus_ADDR=m_ADDR[grant], bus_DAT_O=m_DAT_I[grant].
  - m_ACK[grant]=bus_ACK; every other m_ACK bit is 0.
  - On bus_ACK: go to IDLE. There is 1 dead cycle between transfers.
  - If m_STB[grant] drops before ACK (abort): go to IDLE; requests from other masters are not served in that cycle.
- Requests arriving during BUSY wait; they are never lost because masters hold STB.
- A master that keeps STB high after its ACK competes again in IDLE. Round-robin then places it last.
- m_DAT_O=bus_DAT_I at all times; it is meaningful only in a cycle where that master sees ACK.
- When not in BUSY, bus_WE, bus_ADDR and bus_DAT_O still track master[grant]; only bus_STB is forced to 0.
- grant holds its value in IDLE. busy=(state==BUSY).
- Out-of-range indices (NUM_MASTERS < 2**GRANT_W) are never selected.

Optional Feature:
- WB_ARB_TIMEOUT_EN defined:
  - Counter clears on entry to BUSY and increments each BUSY cycle without bus_ACK.
  - When it reaches TIMEOUT: bus_STB is forced to 0 that cycle, m_ACK[grant]=1 and m_DAT_O=32'h0 for that cycle, bus_err pulses 1, and the FSM returns to IDLE.
  - A real bus_ACK in the same cycle takes precedence: normal ACK, no error.
- WB_ARB_TIMEOUT_EN undefined: no counter is built, BUSY waits indefinitely, and bus_err is tied to 0.

Test Plan:
- Single master: rst, then m_STB=4'b0010 with m_ADDR[1]=32'h2000_0010, slave ACKs 2 cycles after bus_STB -> grant=1 one cycle after request; bus_ADDR=32'h2000_0010; m_ACK=4'b0010 for exactly 1 cycle; m_DAT_O equals bus_DAT_I in that cycle.
- Fairness: all four m_STB held high, each transfer ACKed after 1 cycle -> grant sequence 0,1,2,3,0 with one IDLE cycle between grants.
- Abort: master 2 granted, drops STB before ACK -> back to IDLE next cycle; no m_ACK; the waiting master 3 is granted on the following arbitration.
- Isolation: during master 0's write (m_WE=1, data 32'hCAFE_F00D), master 1 also requests -> bus_DAT_O stays 32'hCAFE_F00D until ACK; m_ACK[1]=0 throughout.
- Reset mid-op: rst asserted in BUSY while bus_ACK=1 -> next cycle busy=0, grant=0, m_ACK=0; the first post-reset request from masters {0,3} goes to 0.
- Timeout (macro on, TIMEOUT=8): slave never ACKs -> after 8 BUSY cycles, m_ACK[grant]=1 with m_DAT_O=0 and bus_err=1 for one cycle, then IDLE.
